// File: rtl/bp_pkg.sv
// Shared definitions for the branch update unit.
// Holds the history and PC widths and the record kept for each in-flight
// branch: its PC, the prediction made at fetch, and the history snapshot
// used to make that prediction.
package bp_pkg;

  localparam int unsigned HIST_W = 3;
  localparam int unsigned PC_W   = 10;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              pred;
    logic [HIST_W-1:0] hist;
  } inflight_t;

endpackage

// File: rtl/bu_inflight_fifo.sv
// In-flight branch FIFO.
// Holds fetched but unresolved branches in program order.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   push_i         append push_data_i at the tail (caller guarantees not full)
//   push_data_i    entry to append
//   pop_i          drop the head entry (caller guarantees not empty)
//   flush_i        discard every entry; wins over push and pop
//   head_o         oldest entry
//   count_o        number of entries held
module bu_inflight_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  inflight_t        push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output inflight_t        head_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  inflight_t        mem_q [DEPTH];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/branch_update_unit.sv
// Branch update unit: tracks local branch history per predictor row and
// replays resolved outcomes back to the predictor in fetch order.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   fetch_valid/pc/pred         branch fetched this cycle and its prediction
//   fetch_ready                 in-flight FIFO has room
//   prev_history                local history for fetch_pc (0 on tag miss)
//   evict                       fetch_pc misses its row; predictor row clears
//   res_valid/res_taken         oldest in-flight branch resolved, and outcome
//   we, old_pc, update_history,
//   branch_taken                one-cycle predictor update for the popped branch
//   mispredict                  pulse with we when the prediction was wrong
//   inflight_count              entries currently held
// Optional build macro BRANCH_STATS_EN adds saturating pred_count and
// mispred_count outputs.
module branch_update_unit
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_valid,
  input  logic [PC_W-1:0]   fetch_pc,
  input  logic              fetch_pred,
  output logic              fetch_ready,
  output logic [HIST_W-1:0] prev_history,
  output logic              evict,
  input  logic              res_valid,
  input  logic              res_taken,
  output logic              we,
  output logic [PC_W-1:0]   old_pc,
  output logic [HIST_W-1:0] update_history,
  output logic              branch_taken,
  output logic              mispredict,
  output logic [3:0]        inflight_count
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]       pred_count,
  output logic [15:0]       mispred_count
`endif
);

  localparam int unsigned ROWS  = 1 << IDX_W;
  localparam int unsigned TAG_W = PC_W - IDX_W;
  localparam logic [3:0]  DEPTH_C = 4'(DEPTH);

  logic              row_valid_q [ROWS];
  logic [TAG_W-1:0]  row_tag_q   [ROWS];
  logic [HIST_W-1:0] row_hist_q  [ROWS];

  logic              we_q, mispredict_q, branch_taken_q;
  logic [PC_W-1:0]   old_pc_q;
  logic [HIST_W-1:0] update_history_q;

  logic [IDX_W-1:0]  fetch_idx, head_idx;
  logic [TAG_W-1:0]  fetch_tag, head_tag;
  logic              fetch_hit, head_hit;
  logic              pop, mis, push;
  inflight_t         head, push_data;
  logic [3:0]        count;

  assign fetch_idx = fetch_pc[IDX_W-1:0];
  assign fetch_tag = fetch_pc[PC_W-1:IDX_W];
  assign fetch_hit = row_valid_q[fetch_idx] && (row_tag_q[fetch_idx] == fetch_tag);

  assign fetch_ready  = (count < DEPTH_C);
  assign prev_history = fetch_hit ? row_hist_q[fetch_idx] : '0;
  assign evict        = fetch_valid && fetch_ready && !fetch_hit;

  assign head_idx = head.pc[IDX_W-1:0];
  assign head_tag = head.pc[PC_W-1:IDX_W];
  assign head_hit = row_valid_q[head_idx] && (row_tag_q[head_idx] == head_tag);

  assign pop  = res_valid && (count != '0);
  assign mis  = pop && (res_taken != head.pred);
  // A mispredict flushes the FIFO, so a fetch in that cycle is discarded.
  assign push = fetch_valid && fetch_ready && !mis;

  assign push_data = '{pc: fetch_pc, pred: fetch_pred, hist: prev_history};

  bu_inflight_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (4)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (mis),
    .head_o      (head),
    .count_o     (count)
  );

  // Resolve shift is written first so that an eviction of the same row in
  // the same cycle overrides it with the fresh tag and cleared history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        row_valid_q[i] <= 1'b0;
        row_tag_q[i]   <= '0;
        row_hist_q[i]  <= '0;
      end
    end else begin
      if (pop && head_hit)
        row_hist_q[head_idx] <= {row_hist_q[head_idx][HIST_W-2:0], res_taken};
      if (evict) begin
        row_valid_q[fetch_idx] <= 1'b1;
        row_tag_q[fetch_idx]   <= fetch_tag;
        row_hist_q[fetch_idx]  <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q             <= 1'b0;
      mispredict_q     <= 1'b0;
      branch_taken_q   <= 1'b0;
      old_pc_q         <= '0;
      update_history_q <= '0;
    end else begin
      we_q         <= pop;
      mispredict_q <= mis;
      if (pop) begin
        branch_taken_q   <= res_taken;
        old_pc_q         <= head.pc;
        update_history_q <= head.hist;
      end
    end
  end

  assign we             = we_q;
  assign mispredict     = mispredict_q;
  assign branch_taken   = branch_taken_q;
  assign old_pc         = old_pc_q;
  assign update_history = update_history_q;
  assign inflight_count = count;

`ifdef BRANCH_STATS_EN
  logic [15:0] pred_count_q, mispred_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pred_count_q    <= '0;
      mispred_count_q <= '0;
    end else begin
      if (pop && (pred_count_q != '1))    pred_count_q    <= pred_count_q + 1'b1;
      if (mis && (mispred_count_q != '1)) mispred_count_q <= mispred_count_q + 1'b1;
    end
  end

  assign pred_count    = pred_count_q;
  assign mispred_count = mispred_count_q;
`endif

endmodule

// File: tb/tb_branch_update_unit.sv
module tb_branch_update_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch_valid;
  logic [9:0] fetch_pc;
  logic       fetch_pred;
  logic       fetch_ready;
  logic [2:0] prev_history;
  logic       evict;
  logic       res_valid;
  logic       res_taken;
  logic       we;
  logic [9:0] old_pc;
  logic [2:0] update_history;
  logic       branch_taken;
  logic       mispredict;
  logic [3:0] inflight_count;
`ifdef BRANCH_STATS_EN
  logic [15:0] pred_count;
  logic [15:0] mispred_count;
`endif

  int total = 0;
  int bad   = 0;

  branch_update_unit #(
    .DEPTH (4),
    .IDX_W (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_valid    (fetch_valid),
    .fetch_pc       (fetch_pc),
    .fetch_pred     (fetch_pred),
    .fetch_ready    (fetch_ready),
    .prev_history   (prev_history),
    .evict          (evict),
    .res_valid      (res_valid),
    .res_taken      (res_taken),
    .we             (we),
    .old_pc         (old_pc),
    .update_history (update_history),
    .branch_taken   (branch_taken),
    .mispredict     (mispredict),
    .inflight_count (inflight_count)
`ifdef BRANCH_STATS_EN
    ,
    .pred_count     (pred_count),
    .mispred_count  (mispred_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; fetch_valid = 1'b0; fetch_pc = '0; fetch_pred = 1'b0;
    res_valid = 1'b0; res_taken = 1'b0;
    #1;
    total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", we); end
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b exp=0", mispredict); end
    total++; if (inflight_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", inflight_count); end
    total++; if (fetch_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", fetch_ready); end
    total++; if (evict !== 1'b0) begin bad++; $display("FAIL reset_evict got=%b exp=0", evict); end
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_evict();
    fetch_valid = 1'b1; fetch_pc = 10'h013; fetch_pred = 1'b1;
    #1;
    total++; if (evict !== 1'b1) begin bad++; $display("FAIL evict_first got=%b exp=1", evict); end
    total++; if (prev_history !== 3'b000) begin bad++; $display("FAIL evict_hist got=%b exp=000", prev_history); end
    step();
    total++; if (evict !== 1'b0) begin bad++; $display("FAIL evict_second got=%b exp=0", evict); end
    total++; if (prev_history !== 3'b000) begin bad++; $display("FAIL evict_hist2 got=%b exp=000", prev_history); end
    fetch_valid = 1'b0;
    total++; if (inflight_count !== 4'd1) begin bad++; $display("FAIL evict_count got=%0d exp=1", inflight_count); end
  endtask

  task automatic test_update();
    res_valid = 1'b1; res_taken = 1'b1;
    step();
    res_valid = 1'b0;
    total++; if (we !== 1'b1) begin bad++; $display("FAIL upd_we got=%b exp=1", we); end
    total++; if (old_pc !== 10'h013) begin bad++; $display("FAIL upd_pc got=%h exp=013", old_pc); end
    total++; if (branch_taken !== 1'b1) begin bad++; $display("FAIL upd_taken got=%b exp=1", branch_taken); end
    total++; if (mispredict !== 1'b0) begin bad++; $display("FAIL upd_mis got=%b exp=0", mispredict); end
    total++; if (update_history !== 3'b000) begin bad++; $display("FAIL upd_hist got=%b exp=000", update_history); end
    total++; if (inflight_count !== 4'd0) begin bad++; $display("FAIL upd_count got=%0d exp=0", inflight_count); end
    fetch_valid = 1'b1; fetch_pc = 10'h013;
    #1;
    total++; if (prev_history !== 3'b001) begin bad++; $display("FAIL upd_row3 got=%b exp=001", prev_history); end
    fetch_valid = 1'b0;
    step();
    total++; if (we !== 1'b0) begin bad++; $display("FAIL upd_we_once got=%b exp=0", we); end
  endtask

  task automatic test_full();
    fetch_valid = 1'b1; fetch_pc = 10'h013; fetch_pred = 1'b1;
    repeat (4) step();
    total++; if (inflight_count !== 4'd4) begin bad++; $display("FAIL full_count got=%0d exp=4", inflight_count); end
    total++; if (fetch_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", fetch_ready); end
    fetch_pc = 10'h025; res_valid = 1'b1; res_taken = 1'b1;
    #1;
    total++; if (evict !== 1'b0) begin bad++; $display("FAIL full_evict got=%b exp=0", evict); end
    step();
    fetch_valid = 1'b0; res_valid = 1'b0;
    total++; if (inflight_count !== 4'd3) begin bad++; $display("FAIL full_drop_count got=%0d exp=3", inflight_count); end
    total++; if (we !== 1'b1 || mispredict !== 1'b0) begin bad++; $display("FAIL full_we got=%b%b exp=10", we, mispredict); end
    total++; if (update_history !== 3'b001) begin bad++; $display("FAIL full_hist got=%b exp=001", update_history); end
    fetch_valid = 1'b1; fetch_pc = 10'h025;
    #1;
    total++; if (evict !== 1'b1) begin bad++; $display("FAIL full_dropped_row got=%b exp=1", evict); end
    fetch_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    res_valid = 1'b1; res_taken = 1'b1;
    for (int i = 2; i >= 0; i--) begin
      step();
      total++; if (we !== 1'b1 || mispredict !== 1'b0) begin bad++; $display("FAIL b2b_we got=%b%b exp=10", we, mispredict); end
      total++; if (inflight_count !== 4'(i)) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", inflight_count, i); end
      total++; if (update_history !== 3'b001) begin bad++; $display("FAIL b2b_hist got=%b exp=001", update_history); end
    end
    res_valid = 1'b0;
    step();
    total++; if (we !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", we); end
    fetch_valid = 1'b1; fetch_pc = 10'h013;
    #1;
    total++; if (prev_history !== 3'b111) begin bad++; $display("FAIL b2b_row3 got=%b exp=111", prev_history); end
    fetch_valid = 1'b0;
  endtask

  task automatic test_mispredict();
    fetch_valid = 1'b1;
    fetch_pc = 10'h020; fetch_pred = 1'b0; step();
    fetch_pc = 10'h031; fetch_pred = 1'b1; step();
    fetch_pc = 10'h042; fetch_pred = 1'b1; step();
    total++; if (inflight_count !== 4'd3) begin bad++; $display("FAIL mis_fill got=%0d exp=3", inflight_count); end
    fetch_pc = 10'h053; fetch_pred = 1'b0; res_valid = 1'b1; res_taken = 1'b1;
    step();
    fetch_valid = 1'b0; res_valid = 1'b0;
    total++; if (mispredict !== 1'b1 || we !== 1'b1) begin bad++; $display("FAIL mis_pulse got=%b%b exp=11", mispredict, we); end
    total++; if (old_pc !== 10'h020) begin bad++; $display("FAIL mis_pc got=%h exp=020", old_pc); end
    total++; if (inflight_count !== 4'd0) begin bad++; $display("FAIL mis_flush got=%0d exp=0", inflight_count); end
    step();
    total++; if (mispredict !== 1'b0 || we !== 1'b0) begin bad++; $display("FAIL mis_once got=%b%b exp=00", mispredict, we); end
    fetch_valid = 1'b1; fetch_pc = 10'h020;
    #1;
    total++; if (prev_history !== 3'b001) begin bad++; $display("FAIL mis_row0 got=%b exp=001", prev_history); end
    fetch_valid = 1'b0;
  endtask

  task automatic test_empty_resolve();
    res_valid = 1'b1; res_taken = 1'b0;
    step();
    res_valid = 1'b0;
    total++; if (we !== 1'b0 || mispredict !== 1'b0) begin bad++; $display("FAIL empty_we got=%b%b exp=00", we, mispredict); end
    total++; if (inflight_count !== 4'd0) begin bad++; $display("FAIL empty_count got=%0d exp=0", inflight_count); end
    fetch_pc = 10'h020;
    #1;
    total++; if (prev_history !== 3'b001) begin bad++; $display("FAIL empty_row0 got=%b exp=001", prev_history); end
  endtask

  task automatic test_same_row();
    fetch_valid = 1'b1; fetch_pc = 10'h020; fetch_pred = 1'b1;
    step();
    res_valid = 1'b1; res_taken = 1'b0;
    #1;
    total++; if (prev_history !== 3'b001) begin bad++; $display("FAIL same_pre got=%b exp=001", prev_history); end
    step();
    fetch_valid = 1'b0; res_valid = 1'b0;
    total++; if (mispredict !== 1'b1 || inflight_count !== 4'd0) begin bad++; $display("FAIL same_mis got=%b/%0d exp=1/0", mispredict, inflight_count); end
    total++; if (prev_history !== 3'b010) begin bad++; $display("FAIL same_post got=%b exp=010", prev_history); end
    step();
  endtask

  task automatic test_reset_mid();
    fetch_valid = 1'b1; fetch_pc = 10'h013; fetch_pred = 1'b1;
    step(); step();
    fetch_valid = 1'b0;
    total++; if (inflight_count !== 4'd2) begin bad++; $display("FAIL rmid_fill got=%0d exp=2", inflight_count); end
    res_valid = 1'b1; res_taken = 1'b1; rst = 1'b1;
    #1;
    total++; if (inflight_count !== 4'd0 || we !== 1'b0) begin bad++; $display("FAIL rmid_clear got=%0d/%b exp=0/0", inflight_count, we); end
    step();
    rst = 1'b0; res_valid = 1'b0;
    step();
    total++; if (we !== 1'b0) begin bad++; $display("FAIL rmid_trail got=%b exp=0", we); end
    fetch_valid = 1'b1; fetch_pc = 10'h020;
    #1;
    total++; if (evict !== 1'b1 || prev_history !== 3'b000) begin bad++; $display("FAIL rmid_rows got=%b/%b exp=1/000", evict, prev_history); end
    fetch_valid = 1'b0;
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    rst = 1'b1; step(); rst = 1'b0;
    total++; if (pred_count !== 16'd0) begin bad++; $display("FAIL stats_reset got=%h exp=0000", pred_count); end
    fetch_pc = 10'h013; fetch_pred = 1'b0; res_taken = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      fetch_valid = 1'b1; res_valid = 1'b0; step();
      fetch_valid = 1'b0; res_valid = 1'b1; step();
    end
    res_valid = 1'b0;
    step();
    total++; if (pred_count !== 16'hFFFF) begin bad++; $display("FAIL stats_pred got=%h exp=ffff", pred_count); end
    total++; if (mispred_count !== 16'hFFFF) begin bad++; $display("FAIL stats_mis got=%h exp=ffff", mispred_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_evict();
    test_update();
    test_full();
    test_back_to_back();
    test_mispredict();
    test_empty_resolve();
    test_same_row();
    test_reset_mid();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
